keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 15: row period is 2^SCAN_DIV clk cycles.
REQ-002 Parameter DEBOUNCE_FRAMES, default 4: number of consecutive identical frames needed for press/release, range 1..15.
REQ-003 Parameter REPEAT_DELAY, default 60: frames held before the first auto-repeat.
REQ-004 Parameter REPEAT_RATE, default 12: frames between auto-repeats.
REQ-005 clk  input  1  system clock.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 col_i  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk.
REQ-008 clear_i  input  1  synchronous clear of entry_o.
REQ-009 row_o  output  4  keypad row drive, active-low, one-hot-low.
REQ-010 key_valid  output  1  one-clk pulse per accepted key event.
REQ-011 key_code  output  4  code of the last accepted key, defined as 4*row+col.
REQ-012 key_held  output  1  high while the debounced key is held.
REQ-013 entry_o  output  32  hex entry register, 8 nibbles, newest nibble in [3:0]; drives a display's text-mode data.

Function
REQ-014 A free-running SCAN_DIV-bit divider SHALL assert scan_tick for one clk on each wrap to 0.
REQ-015 On each scan_tick, row_o SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-016 col_i SHALL pass through a 2-flop synchronizer before any use.
REQ-017 The synchronized columns SHALL be sampled in the clk cycle of scan_tick, before the row advances, into the 4 map bits of the current row.
REQ-018 A frame ends on the scan_tick that samples row 3; frame result SHALL be NONE (0 bits set), ONE(code) (exactly 1 bit set), or MULTI (2 or more bits set).
REQ-019 FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE; transitions are evaluated only at frame end.
REQ-020 IDLE: on ONE(c), latch cand=c, set cnt=1, go to DEBOUNCE; NONE or MULTI stays IDLE.
REQ-021 DEBOUNCE: on ONE(cand), cnt++; when cnt reaches DEBOUNCE_FRAMES, go to PRESSED, set key_code=cand, pulse key_valid. Any other result returns to IDLE.
REQ-022 DEBOUNCE_FRAMES=1: a single ONE frame in IDLE SHALL go directly to PRESSED and emit.
REQ-023 PRESSED: ONE(cand) or MULTI keeps the state (ghosting ignored); ONE(other) or NONE goes to RELEASE with cnt=1.
REQ-024 RELEASE: NONE or ONE(other) increments cnt, and reaching DEBOUNCE_FRAMES goes to IDLE; ONE(cand) or MULTI returns to PRESSED with no new key_valid.
REQ-025 key_held SHALL be 1 in PRESSED and RELEASE, and 0 otherwise.
REQ-026 key_valid SHALL be registered, asserted exactly 1 clk after the frame-end scan_tick, and never high for 2 consecutive clks.
REQ-027 On key_valid, entry_o SHALL become {entry_o[27:0], key_code}; the oldest nibble is discarded.
REQ-028 On clear_i, entry_o SHALL be 0; if clear_i and key_valid coincide, entry_o SHALL be {28'h0, key_code}.
REQ-029 The frame map SHALL clear at each frame start; a partial frame is never evaluated.

Reset
REQ-030 rstn low SHALL asynchronously set: row_o=4'b1110, divider=0, map=0, FSM=IDLE, cnt=0, key_valid=0, key_code=0, key_held=0, entry_o=0.
REQ-031 Reset asserted mid-debounce or mid-press SHALL discard the candidate; after release, no key_valid occurs until a full new debounce completes.

Configuration
REQ-032 Macro KEYPAD_REPEAT_EN defined: in PRESSED, key_valid SHALL pulse again after REPEAT_DELAY frames held, then every REPEAT_RATE frames; a transit through RELEASE resets the repeat counter.
REQ-033 Macro KEYPAD_REPEAT_EN undefined: exactly one key_valid per press, and repeat counters are absent.

Verification (SCAN_DIV=2, DEBOUNCE_FRAMES=2, REPEAT_DELAY=3, REPEAT_RATE=2)
REQ-034 Reset: after rstn rises, row_o=1110; every 4 clks row_o rotates 1101, 1011, 0111, 1110; all other outputs are 0.
REQ-035 Single press: hold key row 2/col 1 (col_i=1101 while row_o=1011) for 3 frames -> one key_valid, key_code=4'h9, entry_o=32'h00000009, key_held=1.
REQ-036 Bounce: key present 1 frame, absent 1 frame, present 1 frame -> no key_valid.
REQ-037 Entry: press codes 1,2,3 in sequence with full releases -> entry_o=32'h00000123; then press with clear_i coincident with key_valid -> entry_o=32'h0000000<code>.
REQ-038 Ghost and release: hold key 5, add key 6 for 1 frame (MULTI) -> no new pulse; release for 2 frames -> key_held=0.
REQ-039 Repeat (KEYPAD_REPEAT_EN): hold key 0 for 10 frames -> key_valid count = 1 + 1 + floor((10-2-3)/2) = 4.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-based debounce and an 8-nibble hex entry register.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key stays held.
module keypad_scan #(
    parameter int unsigned SCAN_DIV        = 15,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned REPEAT_DELAY    = 60,
    parameter int unsigned REPEAT_RATE     = 12
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  col_i,
    input  logic        clear_i,
    output logic [3:0]  row_o,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [31:0] entry_o
);

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    // ------------------------------------------------------------------
    // Row timing
    // ------------------------------------------------------------------
    logic [SCAN_DIV-1:0] div_q;
    logic [1:0]          row_idx_q;
    logic                scan_tick;
    logic                frame_end;

    assign scan_tick = &div_q;
    assign frame_end = scan_tick && (row_idx_q == 2'd3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q     <= '0;
            row_idx_q <= 2'd0;
        end else begin
            div_q <= div_q + (SCAN_DIV)'(1);
            if (scan_tick) begin
                row_idx_q <= row_idx_q + 2'd1;
            end
        end
    end

    always_comb begin
        row_o = 4'b1110;
        unique case (row_idx_q)
            2'd0: row_o = 4'b1110;
            2'd1: row_o = 4'b1101;
            2'd2: row_o = 4'b1011;
            2'd3: row_o = 4'b0111;
            default: row_o = 4'b1110;
        endcase
    end

    // ------------------------------------------------------------------
    // Column synchronizer and frame map
    // ------------------------------------------------------------------
    logic [3:0]  col_s1_q;
    logic [3:0]  col_s2_q;
    logic [15:0] map_q;
    logic [15:0] map_d;
    logic [15:0] frame_map;
    logic [3:0]  frame_code;
    logic        res_none;
    logic        res_one;
    logic        res_multi;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
            map_q    <= '0;
        end else begin
            col_s1_q <= col_i;
            col_s2_q <= col_s1_q;
            map_q    <= map_d;
        end
    end

    // Current row merged in so the frame-end tick sees row 3 without an extra cycle.
    always_comb begin
        frame_map = map_q;
        for (int r = 0; r < 4; r++) begin
            if (row_idx_q == 2'(r)) begin
                frame_map[r*4 +: 4] = ~col_s2_q;
            end
        end
    end

    always_comb begin
        map_d = map_q;
        if (frame_end) begin
            map_d = '0;
        end else if (scan_tick) begin
            map_d = frame_map;
        end
    end

    always_comb begin
        frame_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_map[i]) begin
                frame_code = 4'(i);
            end
        end
    end

    assign res_none  = (frame_map == 16'd0);
    assign res_one   = !res_none && ((frame_map & (frame_map - 16'd1)) == 16'd0);
    assign res_multi = !res_none && !res_one;

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_e     state_q;
    state_e     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] cand_q;
    logic [3:0] cand_d;
    logic       emit;
    logic       same_key;

    assign same_key = res_one && (frame_code == cand_q);

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_N = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE_N  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;
    logic             rep_first_q;
    logic             rep_first_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    logic unused_repeat_params;
    assign unused_repeat_params = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            cand_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (res_one) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                        if (DEB_N <= 4'd1) begin
                            state_d = StPressed;
                            emit    = 1'b1;
                        end else begin
                            state_d = StDebounce;
                        end
                    end
                end
                StDebounce: begin
                    if (same_key) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d >= DEB_N) begin
                            state_d = StPressed;
                            emit    = 1'b1;
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end
                end
                StPressed: begin
                    if (same_key || res_multi) begin
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d = rep_cnt_q + 1'b1;
                        if (rep_first_q ? (rep_cnt_d >= REP_RATE_N)
                                        : (rep_cnt_d >= REP_DELAY_N)) begin
                            emit        = 1'b1;
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b1;
                        end
`endif
                    end else begin
                        cnt_d = 4'd1;
                        if (DEB_N <= 4'd1) begin
                            state_d = StIdle;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = StRelease;
                        end
                    end
                end
                StRelease: begin
                    if (same_key || res_multi) begin
                        state_d = StPressed;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d >= DEB_N) begin
                            state_d = StIdle;
                            cnt_d   = 4'd0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
`ifdef KEYPAD_REPEAT_EN
            // Any fresh press or release transit restarts the repeat schedule.
            if (state_d != StPressed || state_q != StPressed) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        key_held = (state_q == StPressed) || (state_q == StRelease);
    end

    // ------------------------------------------------------------------
    // Key event and entry registers
    // ------------------------------------------------------------------
    logic        key_valid_q;
    logic [3:0]  key_code_q;
    logic [31:0] entry_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            key_valid_q <= emit;
            if (emit) begin
                key_code_q <= cand_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            entry_q <= '0;
        end else if (clear_i) begin
            entry_q <= key_valid_q ? {28'h0, key_code_q} : 32'h0;
        end else if (key_valid_q) begin
            entry_q <= {entry_q[27:0], key_code_q};
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign entry_o   = entry_q;

endmodule
